control_semaforos: RTL and testbench
====================================

CONTROL_SEMAFOROS -- requirements
Module: control_semaforos

Interface
REQ-001 SHALL have parameter T_VERDE_MIN, default 8, minimum A-green cycles before yielding.
REQ-002 SHALL have parameter T_AMARILLO, default 3, yellow duration in enabled cycles for either street.
REQ-003 SHALL have parameter T_TODO_ROJO, default 2, all-red clearance cycles between phases.
REQ-004 SHALL have parameter T_VERDE_B, default 6, fixed B-green duration in enabled cycles.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port enb, input, 1, enable; low freezes the controller.
REQ-008 SHALL have port sensor_b, input, 1, vehicle presence on street B, level-sensitive.
REQ-009 SHALL have port boton_a, input, 1, pedestrian request to cross street A, single-cycle pulse.
REQ-010 SHALL have port boton_b, input, 1, pedestrian request to cross street B, single-cycle pulse.
REQ-011 SHALL have port semaforo_a, output, 2, street A light: 00 red, 01 yellow, 10 green.
REQ-012 SHALL have port semaforo_b, output, 2, street B light, same encoding.
REQ-013 SHALL have port a_peatonal, output, 1, walk signal for crossing street A.
REQ-014 SHALL have port b_peatonal, output, 1, walk signal for crossing street B.
REQ-015 SHALL have port estado, output, 3, current FSM state for debug.

Function
REQ-016 SHALL implement six states: A_VERDE, A_AMARILLO, ROJO_AB, B_VERDE, B_AMARILLO, ROJO_BA, encoded 0-5.
REQ-017 SHALL keep an 8-bit counter cuenta, cleared on every state transition and incremented on each enabled cycle otherwise.
REQ-018 SHALL define demand = sensor_b | pend_a | pend_b.
REQ-019 SHALL leave A_VERDE for A_AMARILLO when cuenta >= T_VERDE_MIN-1 and demand is true; with no demand, A_VERDE is held indefinitely.
REQ-020 SHALL move A_AMARILLO to ROJO_AB after T_AMARILLO cycles.
REQ-021 SHALL move ROJO_AB to B_VERDE after T_TODO_ROJO cycles.
REQ-022 SHALL move B_VERDE to B_AMARILLO after T_VERDE_B cycles.
REQ-023 SHALL move B_AMARILLO to ROJO_BA after T_AMARILLO cycles.
REQ-024 SHALL move ROJO_BA to A_VERDE after T_TODO_ROJO cycles.
REQ-025 SHALL drive the lights by state: A_VERDE 10/00, A_AMARILLO 01/00, ROJO_AB 00/00, B_VERDE 00/10, B_AMARILLO 00/01, ROJO_BA 00/00.
REQ-026 SHALL never drive code 11, and SHALL never drive both lights non-red in the same cycle.
REQ-027 SHALL register all outputs, updating them on the same edge as the state.
REQ-028 SHALL set pend_a on boton_a and pend_b on boton_b, each when enb=1.
REQ-029 SHALL copy pend_a into cruce_a and clear pend_a on the ROJO_AB->B_VERDE edge; a boton_a press on that same edge counts toward cruce_a.
REQ-030 SHALL assert a_peatonal for exactly the B_VERDE cycles when cruce_a=1.
REQ-031 SHALL apply the same rule to pend_b and b_peatonal on the ROJO_BA->A_VERDE edge, asserting b_peatonal only during the first T_VERDE_MIN cycles of A_VERDE.
REQ-032 SHALL, while enb=0, hold state, cuenta, pending flags and outputs, and ignore buttons.
REQ-033 SHALL treat parameter values of 0 as illegal; the minimum legal value is 1.

Reset
REQ-034 SHALL, while reset=0, immediately force: estado=A_VERDE, cuenta=0, semaforo_a=10, semaforo_b=00, peatonales=0, pend/cruce flags=0.
REQ-035 SHALL resume on the first clk edge after reset deasserts, with cuenta starting from 0; reset mid-phase aborts that phase.

Structure
REQ-036 SHALL place state encodings and colour codes (ROJO/AMARILLO/VERDE) in shared include semaforo_defs.vh, also used by calle and calle_tester.
REQ-037 SHALL implement the phase counter as sub-module temporizador, with ports clk, reset, enb, clr, limite and fin.

Verification
REQ-038 SHALL cover: sensor_b=1 held from reset -> A green 8, A yellow 3, all-red 2, B green 6, B yellow 3, all-red 2 cycles; period 24 cycles.
REQ-039 SHALL cover: no inputs for 40 cycles -> semaforo_a=10 and semaforo_b=00 throughout.
REQ-040 SHALL cover: boton_a pulse at cycle 3 -> one full cycle; a_peatonal=1 for exactly the 6 B_VERDE cycles; afterwards the controller returns to A_VERDE and rests.
REQ-041 SHALL cover: enb=0 for 5 cycles during A_AMARILLO -> yellow lasts 8 clocks, all outputs frozen while enb=0.
REQ-042 SHALL cover: reset=0 asynchronously mid-B_VERDE with a_peatonal=1 -> outputs 10/00/0/0 before the next clk edge; pend_a cleared.
REQ-043 SHALL check an invariant monitor on every cycle: no 11 code, never both lights non-red, walk signals only during opposing green.

Source files
------------

// File: rtl/control_semaforos_pkg.sv
// Shared definitions for the two-street traffic light controller:
// state encoding, light colour codes and the state-to-lights mapping.
package control_semaforos_pkg;

  typedef enum logic [2:0] {
    A_VERDE    = 3'd0,
    A_AMARILLO = 3'd1,
    ROJO_AB    = 3'd2,
    B_VERDE    = 3'd3,
    B_AMARILLO = 3'd4,
    ROJO_BA    = 3'd5
  } estado_t;

  localparam logic [1:0] ROJO     = 2'b00;
  localparam logic [1:0] AMARILLO = 2'b01;
  localparam logic [1:0] VERDE    = 2'b10;

  localparam int unsigned CUENTA_W = 8;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } luces_t;

  function automatic luces_t luces_de(estado_t s);
    luces_t l;
    l.a = ROJO;
    l.b = ROJO;
    unique case (s)
      A_VERDE:    l.a = VERDE;
      A_AMARILLO: l.a = AMARILLO;
      B_VERDE:    l.b = VERDE;
      B_AMARILLO: l.b = AMARILLO;
      default:    ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/control_semaforos_temporizador.sv
// Phase timer: counts enabled cycles inside the current phase and flags
// the last cycle of the phase (cuenta >= limite-1).
module temporizador
  import control_semaforos_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enb,
  input  logic                clr,
  input  logic [CUENTA_W-1:0] limite,
  output logic                fin
);

  localparam logic [CUENTA_W-1:0] UNO = CUENTA_W'(1);

  logic [CUENTA_W-1:0] cuenta_q, cuenta_d;

  // Saturates so an indefinitely held A_VERDE never wraps below its limit.
  always_comb begin
    cuenta_d = cuenta_q;
    if (clr)
      cuenta_d = '0;
    else if (enb && (cuenta_q != '1))
      cuenta_d = cuenta_q + UNO;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cuenta_q <= '0;
    else        cuenta_q <= cuenta_d;
  end

  assign fin = (cuenta_q >= (limite - UNO));

endmodule

// File: rtl/control_semaforos.sv
// Two-street traffic light controller with B-street sensor and pedestrian
// requests; A street rests on green until demand appears.
module control_semaforos
  import control_semaforos_pkg::*;
#(
  parameter int unsigned T_VERDE_MIN = 8,
  parameter int unsigned T_AMARILLO  = 3,
  parameter int unsigned T_TODO_ROJO = 2,
  parameter int unsigned T_VERDE_B   = 6
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       sensor_b,
  input  logic       boton_a,
  input  logic       boton_b,
  output logic [1:0] semaforo_a,
  output logic [1:0] semaforo_b,
  output logic       a_peatonal,
  output logic       b_peatonal,
  output logic [2:0] estado
);

  if (T_VERDE_MIN == 0 || T_AMARILLO == 0 || T_TODO_ROJO == 0 || T_VERDE_B == 0 ||
      T_VERDE_MIN > 255 || T_AMARILLO > 255 || T_TODO_ROJO > 255 || T_VERDE_B > 255)
  begin : g_param_ilegal
    $error("control_semaforos: phase durations must be in 1..255");
  end

  localparam logic [CUENTA_W-1:0] LIM_VERDE_MIN = CUENTA_W'(T_VERDE_MIN);
  localparam logic [CUENTA_W-1:0] LIM_AMARILLO  = CUENTA_W'(T_AMARILLO);
  localparam logic [CUENTA_W-1:0] LIM_TODO_ROJO = CUENTA_W'(T_TODO_ROJO);
  localparam logic [CUENTA_W-1:0] LIM_VERDE_B   = CUENTA_W'(T_VERDE_B);

  estado_t             estado_q, estado_d;
  logic [1:0]          sem_a_q, sem_a_d, sem_b_q, sem_b_d;
  logic                a_peat_q, a_peat_d, b_peat_q, b_peat_d;
  logic                pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic                cruce_a_q, cruce_a_d, cruce_b_q, cruce_b_d;
  logic                demanda, fin, clr;
  logic [CUENTA_W-1:0] limite;
  luces_t              luces;

  assign demanda = sensor_b | pend_a_q | pend_b_q;
  assign clr     = (estado_d != estado_q);

  always_comb begin
    unique case (estado_q)
      A_VERDE:               limite = LIM_VERDE_MIN;
      A_AMARILLO, B_AMARILLO: limite = LIM_AMARILLO;
      B_VERDE:               limite = LIM_VERDE_B;
      default:               limite = LIM_TODO_ROJO;
    endcase
  end

  temporizador u_temporizador (
    .clk    (clk),
    .reset  (reset),
    .enb    (enb),
    .clr    (clr),
    .limite (limite),
    .fin    (fin)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= A_VERDE;
      sem_a_q   <= VERDE;
      sem_b_q   <= ROJO;
      a_peat_q  <= 1'b0;
      b_peat_q  <= 1'b0;
      pend_a_q  <= 1'b0;
      pend_b_q  <= 1'b0;
      cruce_a_q <= 1'b0;
      cruce_b_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sem_a_q   <= sem_a_d;
      sem_b_q   <= sem_b_d;
      a_peat_q  <= a_peat_d;
      b_peat_q  <= b_peat_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      cruce_a_q <= cruce_a_d;
      cruce_b_q <= cruce_b_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    if (enb && fin) begin
      unique case (estado_q)
        A_VERDE:    if (demanda) estado_d = A_AMARILLO;
        A_AMARILLO: estado_d = ROJO_AB;
        ROJO_AB:    estado_d = B_VERDE;
        B_VERDE:    estado_d = B_AMARILLO;
        B_AMARILLO: estado_d = ROJO_BA;
        default:    estado_d = A_VERDE;
      endcase
    end
  end

  // Outputs are computed from the next state so they change on the same
  // edge as estado; a press on the hand-over edge still reaches cruce_*.
  always_comb begin
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;
    cruce_a_d = cruce_a_q;
    cruce_b_d = cruce_b_q;
    if (enb) begin
      pend_a_d = pend_a_q | boton_a;
      pend_b_d = pend_b_q | boton_b;
      if (estado_q == ROJO_AB && estado_d == B_VERDE) begin
        cruce_a_d = pend_a_d;
        pend_a_d  = 1'b0;
      end
      if (estado_q == ROJO_BA && estado_d == A_VERDE) begin
        cruce_b_d = pend_b_d;
        pend_b_d  = 1'b0;
      end
    end

    luces    = luces_de(estado_d);
    sem_a_d  = luces.a;
    sem_b_d  = luces.b;
    a_peat_d = (estado_d == B_VERDE) && cruce_a_d;

    // b walk covers the first T_VERDE_MIN cycles of A_VERDE: drop it once the
    // timer reports the last of those cycles.
    if (estado_d != A_VERDE)      b_peat_d = 1'b0;
    else if (estado_q != A_VERDE) b_peat_d = cruce_b_d;
    else                          b_peat_d = b_peat_q && !(enb && fin);
  end

  assign semaforo_a = sem_a_q;
  assign semaforo_b = sem_b_q;
  assign a_peatonal = a_peat_q;
  assign b_peatonal = b_peat_q;
  assign estado     = estado_q;

endmodule

// File: tb/tb_control_semaforos.sv
// Directed self-checking bench for control_semaforos (default parameters).
module tb_control_semaforos;

  logic       clk = 1'b0;
  logic       reset, enb, sensor_b, boton_a, boton_b;
  logic [1:0] semaforo_a, semaforo_b;
  logic       a_peatonal, b_peatonal;
  logic [2:0] estado;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_semaforos #(
    .T_VERDE_MIN (8),
    .T_AMARILLO  (3),
    .T_TODO_ROJO (2),
    .T_VERDE_B   (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .sensor_b   (sensor_b),
    .boton_a    (boton_a),
    .boton_b    (boton_b),
    .semaforo_a (semaforo_a),
    .semaforo_b (semaforo_b),
    .a_peatonal (a_peatonal),
    .b_peatonal (b_peatonal),
    .estado     (estado)
  );

  // Expected {estado, semaforo_a, semaforo_b} for sample p of one full cycle
  // started from A_VERDE with immediate demand; p >= 24 means resting on A.
  function automatic logic [6:0] exp_cycle(int p);
    if (p < 8)       return {3'd0, 2'b10, 2'b00};
    else if (p < 11) return {3'd1, 2'b01, 2'b00};
    else if (p < 13) return {3'd2, 2'b00, 2'b00};
    else if (p < 19) return {3'd3, 2'b00, 2'b10};
    else if (p < 22) return {3'd4, 2'b00, 2'b01};
    else if (p < 24) return {3'd5, 2'b00, 2'b00};
    else             return {3'd0, 2'b10, 2'b00};
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (semaforo_a === 2'b11 || semaforo_b === 2'b11 ||
          (semaforo_a !== 2'b00 && semaforo_b !== 2'b00) ||
          (a_peatonal === 1'b1 && semaforo_b !== 2'b10) ||
          (b_peatonal === 1'b1 && semaforo_a !== 2'b10)) begin
        errors++;
        $display("FAIL invariant t=%0t: a=%b b=%b pa=%b pb=%b", $time,
                 semaforo_a, semaforo_b, a_peatonal, b_peatonal);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0; enb = 1'b1; sensor_b = 1'b0; boton_a = 1'b0; boton_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enb = 1'b1; sensor_b = 1'b0; boton_a = 1'b0; boton_b = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal} !== {3'd0, 2'b10, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: got est=%0d a=%b b=%b pa=%b pb=%b, want est=0 a=10 b=00 pa=0 pb=0",
               estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal);
    end
    do_reset();
  endtask

  task automatic test_sensor_period();
    logic [6:0] e;
    do_reset();
    sensor_b = 1'b1;
    for (int i = 0; i < 48; i++) begin
      e = exp_cycle(i % 24);
      checks++;
      if ({estado, semaforo_a, semaforo_b} !== e) begin
        errors++;
        $display("FAIL sensor_period[%0d]: got est=%0d a=%b b=%b, want %b", i,
                 estado, semaforo_a, semaforo_b, e);
      end
      checks++;
      if ({a_peatonal, b_peatonal} !== 2'b00) begin
        errors++;
        $display("FAIL sensor_walk[%0d]: got %b, want 00", i, {a_peatonal, b_peatonal});
      end
      @(negedge clk);
    end
    sensor_b = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if ({estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal} !== {3'd0, 2'b10, 2'b00, 2'b00}) begin
        errors++;
        $display("FAIL idle[%0d]: got est=%0d a=%b b=%b pa=%b pb=%b, want 0/10/00/0/0", i,
                 estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boton_a();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      e = exp_cycle(i);
      checks++;
      if ({estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal} !== {e, (i >= 13 && i <= 18), 1'b0}) begin
        errors++;
        $display("FAIL boton_a[%0d]: got est=%0d a=%b b=%b pa=%b pb=%b, want %b pa=%b pb=0", i,
                 estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal, e, (i >= 13 && i <= 18));
      end
      boton_a = (i == 3);
      @(negedge clk);
    end
    boton_a = 1'b0;
  endtask

  task automatic test_boton_b();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 46; i++) begin
      e = exp_cycle(i);
      checks++;
      if ({estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal} !== {e, 1'b0, (i >= 24 && i <= 31)}) begin
        errors++;
        $display("FAIL boton_b[%0d]: got est=%0d a=%b b=%b pa=%b pb=%b, want %b pa=0 pb=%b", i,
                 estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal, e, (i >= 24 && i <= 31));
      end
      boton_b = (i == 0);
      @(negedge clk);
    end
    boton_b = 1'b0;
  endtask

  task automatic test_enable_freeze();
    logic [6:0] e;
    do_reset();
    sensor_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 8)       e = {3'd0, 2'b10, 2'b00};
      else if (i < 16) e = {3'd1, 2'b01, 2'b00};
      else if (i < 18) e = {3'd2, 2'b00, 2'b00};
      else             e = {3'd3, 2'b00, 2'b10};
      checks++;
      if ({estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal} !== {e, 2'b00}) begin
        errors++;
        $display("FAIL enable_freeze[%0d]: got est=%0d a=%b b=%b pa=%b pb=%b, want %b pa=0 pb=0", i,
                 estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal, e);
      end
      enb     = !(i >= 9 && i < 14);
      boton_a = (i == 11);
      boton_b = (i == 12);
      @(negedge clk);
    end
    enb = 1'b1; boton_a = 1'b0; boton_b = 1'b0; sensor_b = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      boton_a = (i == 3);
      if (i < 15) @(negedge clk);
    end
    boton_a = 1'b0;
    checks++;
    if ({estado, a_peatonal} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_walk: got est=%0d pa=%b, want est=3 pa=1", estado, a_peatonal);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal} !== {3'd0, 2'b10, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL async_reset: got est=%0d a=%b b=%b pa=%b pb=%b, want 0/10/00/0/0",
               estado, semaforo_a, semaforo_b, a_peatonal, b_peatonal);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if ({estado, semaforo_a, semaforo_b, a_peatonal} !== {3'd0, 2'b10, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL pend_a_cleared[%0d]: got est=%0d a=%b b=%b pa=%b, want 0/10/00/0", i,
                 estado, semaforo_a, semaforo_b, a_peatonal);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_long_hold();
    do_reset();
    repeat (300) @(negedge clk);
    checks++;
    if ({estado, semaforo_a} !== {3'd0, 2'b10}) begin
      errors++;
      $display("FAIL long_hold: got est=%0d a=%b, want est=0 a=10", estado, semaforo_a);
    end
    sensor_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({estado, semaforo_a, semaforo_b} !== {3'd1, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL long_hold_leave: got est=%0d a=%b b=%b, want est=1 a=01 b=00",
               estado, semaforo_a, semaforo_b);
    end
    sensor_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sensor_period();
    test_idle();
    test_boton_a();
    test_boton_b();
    test_enable_freeze();
    test_async_reset();
    test_long_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
